// File: rtl/cpu_types_pkg.sv
// Shared types for the hazard/forwarding producer.
// Stage tags carried down EX, MEM and WB.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } hazard_state_t;

  typedef struct packed {
    regbits_t rs;
    regbits_t rt;
    regbits_t rd;
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     alusrc;
  } stage_tag_t;

  localparam stage_tag_t NOP_TAG = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tag register.
// Holds when disabled; clear loads a bubble.
import cpu_types_pkg::*;

module hazard_stage_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  // Advance, bubble or hold the stage tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= NOP_TAG;
    end else if (en_i) begin
      q_o <= clr_i ? NOP_TAG : d_i;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tag pipeline, load-use detect, flush and
// memory-wait freeze for the forwarding unit.
import cpu_types_pkg::*;

module hazard_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             branch_flush,
  input  logic             dmem_wait,
  output logic [4:0]       idex_register_rs,
  output logic [4:0]       idex_register_rt,
  output logic [4:0]       exmem_register_rd,
  output logic             exmem_regwrite,
  output logic [4:0]       memwb_register_rd,
  output logic             memwb_regwrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             alusrc,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  hazard_state_t    state_q;
  stage_tag_t       id_tag;
  stage_tag_t       ex_q;
  stage_tag_t       mem_q;
  stage_tag_t       wb_q;
  logic             lu_hit;
  logic             lu;
  logic             mem_ls;
  logic             ex_clr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_tags;

  // Invalid ID slots enter EX as bubbles
  always_comb begin
    id_tag = NOP_TAG;
    if (id_valid) begin
      id_tag.rs       = id_rs;
      id_tag.rt       = id_rt;
      id_tag.rd       = id_rd;
      id_tag.regwrite = id_regwrite;
      id_tag.memread  = id_memread;
      id_tag.memwrite = id_memwrite;
      id_tag.alusrc   = id_alusrc;
    end
  end

  assign lu_hit = ex_q.memread
               && (ex_q.rd != '0)
               && id_valid
               && ((ex_q.rd == id_rs)
                || (id_uses_rt && (ex_q.rd == id_rt)));

  assign lu     = lu_hit && (state_q != LU_STALL);
  assign mem_ls = mem_q.memread || mem_q.memwrite;

  // Release in the same cycle the access completes
  assign freeze = dmem_wait
               && (mem_ls || (state_q == MEM_WAIT));

  assign stall_if_id = lu && !freeze && !branch_flush;
  assign bubble_ex   = lu && !freeze && !branch_flush;
  assign ex_clr      = branch_flush || lu;

  hazard_stage_reg u_ex (
    .clk   (CLK),
    .rst_n (nRST),
    .en_i  (!freeze),
    .clr_i (ex_clr),
    .d_i   (id_tag),
    .q_o   (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk   (CLK),
    .rst_n (nRST),
    .en_i  (!freeze),
    .clr_i (1'b0),
    .d_i   (ex_q),
    .q_o   (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk   (CLK),
    .rst_n (nRST),
    .en_i  (!freeze),
    .clr_i (1'b0),
    .d_i   (mem_q),
    .q_o   (wb_q)
  );

  // Hazard FSM; a pending memory access overrides everything
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else if (dmem_wait && mem_ls) begin
      state_q <= MEM_WAIT;
    end else begin
      unique case (state_q)
        RUN:      if (stall_if_id) state_q <= LU_STALL;
        LU_STALL: state_q <= RUN;
        MEM_WAIT: if (!dmem_wait) state_q <= RUN;
        default:  state_q <= RUN;
      endcase
    end
  end

  assign cnt_d = ((stall_if_id || freeze) && (cnt_q != '1))
               ? cnt_q + 1'b1 : cnt_q;

  // Saturating stall-cycle counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idex_register_rs  = ex_q.rs;
  assign idex_register_rt  = ex_q.rt;
  assign MemRead           = ex_q.memread;
  assign MemWrite          = ex_q.memwrite;
  assign alusrc            = ex_q.alusrc;
  assign exmem_register_rd = mem_q.rd;
  assign exmem_regwrite    = mem_q.regwrite;
  assign memwb_register_rd = wb_q.rd;
  assign memwb_regwrite    = wb_q.regwrite;
  assign stall_cycles      = cnt_q;

  assign unused_tags = ^{ex_q.rd, ex_q.regwrite,
                         mem_q.rs, mem_q.rt, mem_q.alusrc,
                         wb_q.rs, wb_q.rt, wb_q.memread,
                         wb_q.memwrite, wb_q.alusrc};

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker.
// Each task drives one scenario and checks inline.
import cpu_types_pkg::*;

module tb_hazard_tracker;

  logic       CLK;
  logic       nRST;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_memwrite;
  logic       id_alusrc;
  logic       branch_flush;
  logic       dmem_wait;
  logic [4:0] idex_register_rs;
  logic [4:0] idex_register_rt;
  logic [4:0] exmem_register_rd;
  logic       exmem_regwrite;
  logic [4:0] memwb_register_rd;
  logic       memwb_regwrite;
  logic       MemRead;
  logic       MemWrite;
  logic       alusrc;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       freeze;
  logic [3:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_tracker #(.CNT_W(4)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .id_valid          (id_valid),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rt        (id_uses_rt),
    .id_rd             (id_rd),
    .id_regwrite       (id_regwrite),
    .id_memread        (id_memread),
    .id_memwrite       (id_memwrite),
    .id_alusrc         (id_alusrc),
    .branch_flush      (branch_flush),
    .dmem_wait         (dmem_wait),
    .idex_register_rs  (idex_register_rs),
    .idex_register_rt  (idex_register_rt),
    .exmem_register_rd (exmem_register_rd),
    .exmem_regwrite    (exmem_regwrite),
    .memwb_register_rd (memwb_register_rd),
    .memwb_regwrite    (memwb_regwrite),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .alusrc            (alusrc),
    .stall_if_id       (stall_if_id),
    .bubble_ex         (bubble_ex),
    .freeze            (freeze),
    .stall_cycles      (stall_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic urt,
                       input logic [4:0] rd,
                       input logic rw,
                       input logic mr,
                       input logic mw,
                       input logic as);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
    id_alusrc   = as;
  endtask

  task automatic drive_nop;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    cycle();
    nRST = 0;
    drive_nop();
    dmem_wait    = 0;
    branch_flush = 0;
    #2;
    nRST = 1;
  endtask

  task automatic test_reset;
    cycle();
    drive(1, 3, 0, 0, 8, 1, 1, 0, 0);
    cycle();
    drive_nop();
    #1;
    checks++;
    if (MemRead !== 1'b1) begin
      $display("FAIL rst_pre_memread got %0b want 1", MemRead);
      errors++;
    end
    cycle();
    dmem_wait = 1;
    #1;
    checks++;
    if (freeze !== 1'b1) begin
      $display("FAIL rst_pre_freeze got %0b want 1", freeze);
      errors++;
    end
    cycle();
    #2;
    nRST = 0;
    #1;
    checks++;
    if (exmem_register_rd !== 5'd0 || exmem_regwrite !== 1'b0) begin
      $display("FAIL rst_mem got rd=%0d rw=%0b want 0/0",
               exmem_register_rd, exmem_regwrite);
      errors++;
    end
    checks++;
    if (freeze !== 1'b0 || stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin
      $display("FAIL rst_ctrl got frz=%0b st=%0b bub=%0b want 0",
               freeze, stall_if_id, bubble_ex);
      errors++;
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      $display("FAIL rst_cnt got %0d want 0", stall_cycles);
      errors++;
    end
    checks++;
    if (dut.state_q !== RUN) begin
      $display("FAIL rst_state got %0d want 0", dut.state_q);
      errors++;
    end
    checks++;
    if (MemRead !== 1'b0 || idex_register_rs !== 5'd0
        || memwb_regwrite !== 1'b0) begin
      $display("FAIL rst_tags got mr=%0b rs=%0d wbrw=%0b want 0",
               MemRead, idex_register_rs, memwb_regwrite);
      errors++;
    end
    dmem_wait = 0;
    nRST = 1;
  endtask

  task automatic test_load_use;
    do_reset();
    drive(1, 3, 0, 0, 8, 1, 1, 0, 0);
    #1;
    checks++;
    if (stall_if_id !== 1'b0) begin
      $display("FAIL lu_idle got %0b want 0", stall_if_id);
      errors++;
    end
    cycle();
    drive(1, 8, 10, 1, 9, 1, 0, 0, 0);
    #1;
    checks++;
    if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin
      $display("FAIL lu_stall got st=%0b bub=%0b want 1/1",
               stall_if_id, bubble_ex);
      errors++;
    end
    cycle();
    #1;
    checks++;
    if (stall_if_id !== 1'b0 || MemRead !== 1'b0) begin
      $display("FAIL lu_bubble got st=%0b mr=%0b want 0/0",
               stall_if_id, MemRead);
      errors++;
    end
    checks++;
    if (exmem_register_rd !== 5'd8 || stall_cycles !== 4'd1) begin
      $display("FAIL lu_mem got rd=%0d cnt=%0d want 8/1",
               exmem_register_rd, stall_cycles);
      errors++;
    end
    cycle();
    drive_nop();
    #1;
    checks++;
    if (idex_register_rs !== 5'd8 || idex_register_rt !== 5'd10) begin
      $display("FAIL lu_ex got rs=%0d rt=%0d want 8/10",
               idex_register_rs, idex_register_rt);
      errors++;
    end
    checks++;
    if (memwb_register_rd !== 5'd8 || memwb_regwrite !== 1'b1
        || stall_cycles !== 4'd1) begin
      $display("FAIL lu_wb got rd=%0d rw=%0b cnt=%0d want 8/1/1",
               memwb_register_rd, memwb_regwrite, stall_cycles);
      errors++;
    end
  endtask

  task automatic test_no_stall;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 1);
    cycle();
    drive(1, 0, 0, 1, 9, 1, 0, 0, 0);
    #1;
    checks++;
    if (stall_if_id !== 1'b0) begin
      $display("FAIL ns_r0 got %0b want 0", stall_if_id);
      errors++;
    end
    cycle();
    drive(1, 3, 0, 0, 8, 1, 1, 0, 1);
    cycle();
    drive(1, 10, 8, 0, 9, 1, 0, 0, 1);
    #1;
    checks++;
    if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin
      $display("FAIL ns_rt got st=%0b bub=%0b want 0/0",
               stall_if_id, bubble_ex);
      errors++;
    end
    cycle();
    drive_nop();
    #1;
    checks++;
    if (alusrc !== 1'b1 || idex_register_rt !== 5'd8
        || stall_cycles !== 4'd0) begin
      $display("FAIL ns_ex got as=%0b rt=%0d cnt=%0d want 1/8/0",
               alusrc, idex_register_rt, stall_cycles);
      errors++;
    end
  endtask

  task automatic test_mem_wait;
    do_reset();
    drive(1, 4, 5, 1, 0, 0, 0, 1, 1);
    cycle();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0);
    cycle();
    drive(1, 6, 7, 1, 11, 1, 0, 0, 0);
    dmem_wait = 1;
    #1;
    checks++;
    if (freeze !== 1'b1 || stall_if_id !== 1'b0) begin
      $display("FAIL mw_c1 got frz=%0b st=%0b want 1/0",
               freeze, stall_if_id);
      errors++;
    end
    cycle();
    #1;
    checks++;
    if (freeze !== 1'b1 || idex_register_rs !== 5'd1) begin
      $display("FAIL mw_c2 got frz=%0b rs=%0d want 1/1",
               freeze, idex_register_rs);
      errors++;
    end
    cycle();
    #1;
    checks++;
    if (freeze !== 1'b1 || exmem_regwrite !== 1'b0
        || MemWrite !== 1'b0) begin
      $display("FAIL mw_c3 got frz=%0b rw=%0b mw=%0b want 1/0/0",
               freeze, exmem_regwrite, MemWrite);
      errors++;
    end
    cycle();
    dmem_wait = 0;
    #1;
    checks++;
    if (freeze !== 1'b0 || stall_cycles !== 4'd3
        || idex_register_rs !== 5'd1) begin
      $display("FAIL mw_rel got frz=%0b cnt=%0d rs=%0d want 0/3/1",
               freeze, stall_cycles, idex_register_rs);
      errors++;
    end
    cycle();
    #1;
    checks++;
    if (idex_register_rs !== 5'd6 || exmem_register_rd !== 5'd3
        || memwb_regwrite !== 1'b0 || stall_cycles !== 4'd3) begin
      $display("FAIL mw_adv got rs=%0d rd=%0d wbrw=%0b cnt=%0d want 6/3/0/3",
               idex_register_rs, exmem_register_rd,
               memwb_regwrite, stall_cycles);
      errors++;
    end
  endtask

  task automatic test_flush;
    do_reset();
    drive(1, 1, 2, 1, 20, 1, 0, 0, 0);
    cycle();
    drive(1, 3, 0, 0, 8, 1, 1, 0, 0);
    cycle();
    drive(1, 8, 10, 1, 9, 1, 0, 0, 0);
    branch_flush = 1;
    #1;
    checks++;
    if (stall_if_id !== 1'b0) begin
      $display("FAIL fl_stall got %0b want 0", stall_if_id);
      errors++;
    end
    cycle();
    branch_flush = 0;
    drive_nop();
    #1;
    checks++;
    if (idex_register_rs !== 5'd0 || idex_register_rt !== 5'd0
        || MemRead !== 1'b0) begin
      $display("FAIL fl_ex got rs=%0d rt=%0d mr=%0b want 0/0/0",
               idex_register_rs, idex_register_rt, MemRead);
      errors++;
    end
    checks++;
    if (exmem_register_rd !== 5'd8 || exmem_regwrite !== 1'b1
        || memwb_register_rd !== 5'd20 || memwb_regwrite !== 1'b1) begin
      $display("FAIL fl_memwb got %0d/%0b %0d/%0b want 8/1 20/1",
               exmem_register_rd, exmem_regwrite,
               memwb_register_rd, memwb_regwrite);
      errors++;
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      $display("FAIL fl_cnt got %0d want 0", stall_cycles);
      errors++;
    end
  endtask

  task automatic test_saturate;
    do_reset();
    drive(1, 4, 5, 1, 0, 0, 0, 1, 1);
    cycle();
    drive_nop();
    cycle();
    dmem_wait = 1;
    repeat (14) cycle();
    checks++;
    if (stall_cycles !== 4'd14) begin
      $display("FAIL sat_14 got %0d want 14", stall_cycles);
      errors++;
    end
    cycle();
    checks++;
    if (stall_cycles !== 4'hF) begin
      $display("FAIL sat_15 got %0d want 15", stall_cycles);
      errors++;
    end
    repeat (5) cycle();
    checks++;
    if (stall_cycles !== 4'hF) begin
      $display("FAIL sat_hold got %0d want 15", stall_cycles);
      errors++;
    end
    dmem_wait = 0;
    cycle();
    checks++;
    if (stall_cycles !== 4'hF || freeze !== 1'b0) begin
      $display("FAIL sat_end got cnt=%0d frz=%0b want 15/0",
               stall_cycles, freeze);
      errors++;
    end
  endtask

  initial begin
    CLK          = 0;
    nRST         = 0;
    dmem_wait    = 0;
    branch_flush = 0;
    drive_nop();
    #12;
    nRST = 1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_mem_wait();
    test_flush();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
